// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round sequencer.
//   state_e    : sequencer state encoding (also visible on the debug state port)
//   HOLE_IDX_W : width of the random hole index coming from the generator
//   sat_inc    : saturating increment for counters of any width up to 32 bits
package mole_pkg;

  localparam int HOLE_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPAWN  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HIT    = 3'd3,
    ST_GAP    = 3'd4,
    ST_OVER   = 3'd5
  } state_e;

  // Increment v, but stop at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mole_scheduler_if.sv
// Signal bundle between the round sequencer and its neighbours (random
// generator, keys, LED/score display).
//   master : the surroundings (drives start, ran_pos, hit_key)
//   slave  : mole_scheduler (drives ran_req, mole, score, miss, busy,
//            game_over and the debug state_dbg)
// Handshake: there is no valid/ready pair here. ran_req is a one-cycle strobe
// marking the cycle in which ran_pos is sampled; the generator must hold
// ran_pos stable before that rising edge and gets no acknowledge back. start
// is a level that is acted on whenever the sequencer is in IDLE or OVER.
interface mole_scheduler_if
  import mole_pkg::*;
#(
  parameter int NUM_HOLES = 8,
  parameter int CNT_W     = 8
) ();

  logic                  start;
  logic [HOLE_IDX_W-1:0] ran_pos;
  logic [NUM_HOLES-1:0]  hit_key;

  logic                  ran_req;
  logic [NUM_HOLES-1:0]  mole;
  logic [CNT_W-1:0]      score;
  logic [CNT_W-1:0]      miss;
  logic                  busy;
  logic                  game_over;
  state_e                state_dbg;

  modport master (
    output start, ran_pos, hit_key,
    input  ran_req, mole, score, miss, busy, game_over, state_dbg
  );

  modport slave (
    input  start, ran_pos, hit_key,
    output ran_req, mole, score, miss, busy, game_over, state_dbg
  );

endinterface

// File: rtl/mole_life_timer.sv
// Loadable down-counter with a zero flag. Used by the sequencer both for the
// lit lifetime of a mole and for the dark gap between rounds.
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (wins over dec)
//   load_val  : value to load
//   dec       : decrement by one, holding at zero
//   zero      : count is zero (from the register)
module mole_life_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mole_scheduler.sv
// Round sequencer for the whack-a-mole game. Each round samples the random hole
// index once, lights one mole for a bounded lifetime, and scores a hit or a
// miss. The game ends after GAME_ROUNDS rounds.
// Ports:
//   clk, rst : game clock (rising edge), asynchronous active-high reset
//   bus      : mole_scheduler_if.slave
//              in : start, ran_pos, hit_key
//              out: ran_req, mole, score, miss, busy, game_over, state_dbg
// All outputs are registered; they are computed from the next state so that
// e.g. ran_req is high exactly while the FSM sits in SPAWN.
// Optional feature macro: DIFFICULTY_RAMP_EN -- every 4th hit shortens the lit
// lifetime by one cycle (floor 1), applied from the next SPAWN and restored to
// LIFE_TICKS on start. Without the macro the lifetime is fixed.
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int NUM_HOLES   = 8,
  parameter int LIFE_TICKS  = 3,
  parameter int GAP_TICKS   = 1,
  parameter int GAME_ROUNDS = 20,
  parameter int CNT_W       = 8
) (
  input logic              clk,
  input logic              rst,
  mole_scheduler_if.slave  bus
);

  localparam int TMR_MAX = (LIFE_TICKS > GAP_TICKS) ? LIFE_TICKS : GAP_TICKS;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0]     LIFE_LOAD = TMR_W'(LIFE_TICKS - 1);
  localparam logic [TMR_W-1:0]     GAP_LOAD  = TMR_W'(GAP_TICKS - 1);
  localparam logic [NUM_HOLES-1:0] ONE_HOT0  = NUM_HOLES'(1);
  localparam logic [HOLE_IDX_W-1:0] LAST_HOLE = HOLE_IDX_W'(NUM_HOLES - 1);

  state_e                state_q, state_d;
  logic [HOLE_IDX_W-1:0] pos_q, pos_d;
  logic [HOLE_IDX_W-1:0] prev_pos_q, prev_pos_d;
  logic [7:0]            round_q, round_d;
  logic [CNT_W-1:0]      score_q, score_d;
  logic [CNT_W-1:0]      miss_q, miss_d;
  logic [NUM_HOLES-1:0]  mole_q, mole_d;
  logic                  ran_req_q, ran_req_d;
  logic                  busy_q, busy_d;
  logic                  game_over_q, game_over_d;

  logic                  tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0]      tmr_load_val;
  logic [TMR_W-1:0]      life_load;

  logic [HOLE_IDX_W-1:0] folded_pos, spawn_pos;
  logic                  hit_now;
  logic                  start_game;
  logic                  score_hit;

  mole_life_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Fold the raw index into range, then step past the previous hole so the
  // same hole never lights twice in a row (except across a game restart).
  always_comb begin
    folded_pos = HOLE_IDX_W'(32'(bus.ran_pos) % 32'(NUM_HOLES));
    spawn_pos  = folded_pos;
    if ((folded_pos == prev_pos_q) && (round_q != 8'd0)) begin
      spawn_pos = (folded_pos == LAST_HOLE) ? '0 : folded_pos + HOLE_IDX_W'(1);
    end
  end

  // Only the key under the lit hole counts.
  assign hit_now = |(bus.hit_key & (ONE_HOT0 << pos_q));

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    prev_pos_d   = prev_pos_q;
    round_d      = round_q;
    score_d      = score_q;
    miss_d       = miss_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    start_game   = 1'b0;
    score_hit    = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          state_d    = ST_SPAWN;
          score_d    = '0;
          miss_d     = '0;
          round_d    = '0;
          start_game = 1'b1;
        end
      end
      ST_SPAWN: begin
        pos_d        = spawn_pos;
        prev_pos_d   = spawn_pos;
        round_d      = round_q + 8'd1;
        tmr_load     = 1'b1;
        tmr_load_val = life_load;
        state_d      = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // A hit on the final lit cycle still counts as a hit.
        if (hit_now) begin
          state_d   = ST_HIT;
          score_d   = CNT_W'(sat_inc(32'(score_q), CNT_W));
          score_hit = 1'b1;
        end else if (tmr_zero) begin
          state_d      = ST_GAP;
          miss_d       = CNT_W'(sat_inc(32'(miss_q), CNT_W));
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LOAD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_HIT: begin
        state_d      = ST_GAP;
        tmr_load     = 1'b1;
        tmr_load_val = GAP_LOAD;
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = (round_q == 8'(GAME_ROUNDS)) ? ST_OVER : ST_SPAWN;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ran_req_d   = (state_d == ST_SPAWN);
    busy_d      = (state_d == ST_SPAWN) || (state_d == ST_ACTIVE) ||
                  (state_d == ST_HIT)   || (state_d == ST_GAP);
    game_over_d = (state_d == ST_OVER);
    mole_d      = (state_d == ST_ACTIVE) ? (ONE_HOT0 << pos_d) : '0;
  end

`ifdef DIFFICULTY_RAMP_EN
  logic [7:0] life_eff_q, life_eff_d;
  logic [1:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    life_eff_d = life_eff_q;
    hit_cnt_d  = hit_cnt_q;
    if (start_game) begin
      life_eff_d = 8'(LIFE_TICKS);
      hit_cnt_d  = '0;
    end else if (score_hit) begin
      hit_cnt_d = hit_cnt_q + 2'd1;
      if ((hit_cnt_q == 2'd3) && (life_eff_q > 8'd1)) begin
        life_eff_d = life_eff_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      life_eff_q <= 8'(LIFE_TICKS);
      hit_cnt_q  <= '0;
    end else begin
      life_eff_q <= life_eff_d;
      hit_cnt_q  <= hit_cnt_d;
    end
  end

  assign life_load = TMR_W'(life_eff_q - 8'd1);
`else
  assign life_load = LIFE_LOAD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      prev_pos_q  <= '0;
      round_q     <= '0;
      score_q     <= '0;
      miss_q      <= '0;
      mole_q      <= '0;
      ran_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      prev_pos_q  <= prev_pos_d;
      round_q     <= round_d;
      score_q     <= score_d;
      miss_q      <= miss_d;
      mole_q      <= mole_d;
      ran_req_q   <= ran_req_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.ran_req   = ran_req_q;
  assign bus.mole      = mole_q;
  assign bus.score     = score_q;
  assign bus.miss      = miss_q;
  assign bus.busy      = busy_q;
  assign bus.game_over = game_over_q;
  assign bus.state_dbg = state_q;

endmodule
